interpreter_receiver: RTL and testbench

Inbound counterpart of the processor's interpreter output link: receives a length-prefixed byte stream from the external interpreter on a strobe/byte-bus pair, packs the bytes into 32-bit little-endian words and writes them into data memory. It sits beside the data RAM in the top level and drives a write port (MemWrite / Address / WriteData) while the CPU is held in start-wait, so the interpreter can preload program data before execution.

---
 rtl/interpreter_receiver.sv | 218 +++++++++++++++++++++
 tb/tb_interpreter_receiver.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/interpreter_receiver.sv
// interpreter_receiver
//
// Inbound half of the interpreter link. The external interpreter sends a
// length-prefixed byte stream on a strobe/byte-bus pair. The stream is a
// 16-bit word count N (high byte first) followed by 4*N data bytes. The
// bytes are packed little-endian into 32-bit words, and each word is written
// into data memory through a single-cycle write port. This runs while the
// CPU waits to start, so the interpreter can preload program data.
//
// Parameters:
//   ADDR_W     width of Address and WordCount
//   BASE_ADDR  byte address of the first word written
//
// Ports:
//   clk        system clock (shared with CPU / data memory)
//   reset      asynchronous, active-low reset
//   start      one-cycle pulse arming a reception (honoured in IDLE/DONE only)
//   clk_in     interpreter byte strobe, asynchronous to clk
//   DataIn     interpreter byte bus, valid around the clk_in rising edge
//   MemWrite   one-cycle data-memory write enable
//   Address    byte address of the current write
//   WriteData  word being written
//   Busy       high from an accepted start until DONE
//   Done       high in DONE until the next accepted start or reset
//   WordCount  words written in the current/last transfer
//   ChkErr     checksum mismatch flag
//
// Optional feature: define RX_CHECKSUM_EN to expect one trailing byte equal
// to the XOR of all data bytes. Without it ChkErr is tied low.

module interpreter_receiver #(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              clk_in,
    input  logic [7:0]        DataIn,
    output logic              MemWrite,
    output logic [ADDR_W-1:0] Address,
    output logic [31:0]       WriteData,
    output logic              Busy,
    output logic              Done,
    output logic [ADDR_W-1:0] WordCount,
    output logic              ChkErr
);

    typedef enum logic [2:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        DATA,
        WRITE,
`ifdef RX_CHECKSUM_EN
        CHK,
`endif
        DONE
    } state_t;

    // The state that follows the last data word (or a zero length).
`ifdef RX_CHECKSUM_EN
    localparam state_t AFTER_DATA = CHK;
`else
    localparam state_t AFTER_DATA = DONE;
`endif

    state_t            state;
    state_t            next_state;

    logic              sync1;
    logic              sync2;
    logic              hist;
    logic              strobe;

    logic [7:0]        len_hi;
    logic [15:0]       len_word;
    logic [ADDR_W-1:0] n_ext;
    logic [ADDR_W-1:0] len_now;
    logic [ADDR_W-1:0] wc_next;
    logic [1:0]        byte_idx;

`ifdef RX_CHECKSUM_EN
    logic [7:0]        chk_acc;
`endif

    // A strobe is a rising edge of the synchronized clk_in.
    assign strobe  = sync2 & ~hist;

    // Length as seen while the low byte is on the bus. It is used to
    // detect N=0 in the same cycle the byte arrives.
    assign len_now = ADDR_W'({len_hi, DataIn});
    assign n_ext   = ADDR_W'(len_word);
    assign wc_next = WordCount + {{(ADDR_W-1){1'b0}}, 1'b1};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        MemWrite   = 1'b0;
        Busy       = 1'b1;
        Done       = 1'b0;
        case (state)
            IDLE: begin
                Busy = 1'b0;
                if (start) next_state = LEN_HI;
            end
            LEN_HI: begin
                if (strobe) next_state = LEN_LO;
            end
            LEN_LO: begin
                if (strobe) next_state = (len_now == '0) ? AFTER_DATA : DATA;
            end
            DATA: begin
                if (strobe && byte_idx == 2'd3) next_state = WRITE;
            end
            WRITE: begin
                MemWrite   = 1'b1;
                next_state = (wc_next == n_ext) ? AFTER_DATA : DATA;
            end
`ifdef RX_CHECKSUM_EN
            CHK: begin
                if (strobe) next_state = DONE;
            end
`endif
            DONE: begin
                Busy = 1'b0;
                Done = 1'b1;
                if (start) next_state = LEN_HI;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Synchronizer, length capture, byte packing, address and word counting.
    // Address is loaded on the fourth byte so that it is already stable
    // during the WRITE cycle. Outside WRITE it keeps its last value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            hist      <= 1'b0;
            len_hi    <= 8'h00;
            len_word  <= 16'h0000;
            byte_idx  <= 2'd0;
            WriteData <= 32'h0000_0000;
            Address   <= BASE_ADDR;
            WordCount <= '0;
`ifdef RX_CHECKSUM_EN
            chk_acc   <= 8'h00;
            ChkErr    <= 1'b0;
`endif
        end else begin
            sync1 <= clk_in;
            sync2 <= sync1;
            hist  <= sync2;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        WordCount <= '0;
                        byte_idx  <= 2'd0;
`ifdef RX_CHECKSUM_EN
                        chk_acc   <= 8'h00;
                        ChkErr    <= 1'b0;
`endif
                    end
                end
                LEN_HI: begin
                    if (strobe) len_hi <= DataIn;
                end
                LEN_LO: begin
                    if (strobe) len_word <= {len_hi, DataIn};
                end
                DATA: begin
                    if (strobe) begin
                        case (byte_idx)
                            2'd0:    WriteData[7:0]   <= DataIn;
                            2'd1:    WriteData[15:8]  <= DataIn;
                            2'd2:    WriteData[23:16] <= DataIn;
                            default: WriteData[31:24] <= DataIn;
                        endcase
                        byte_idx <= byte_idx + 2'd1;
`ifdef RX_CHECKSUM_EN
                        chk_acc  <= chk_acc ^ DataIn;
`endif
                        if (byte_idx == 2'd3) begin
                            Address <= BASE_ADDR + (WordCount << 2);
                        end
                    end
                end
                WRITE: begin
                    WordCount <= wc_next;
                    byte_idx  <= 2'd0;
                end
`ifdef RX_CHECKSUM_EN
                CHK: begin
                    if (strobe) ChkErr <= (DataIn != chk_acc);
                end
`endif
                default: begin
                end
            endcase
        end
    end

`ifndef RX_CHECKSUM_EN
    assign ChkErr = 1'b0;
`endif

endmodule

// File: tb/tb_interpreter_receiver.sv
// Testbench for interpreter_receiver.
// It drives the byte strobe the way a real interpreter would. It predicts
// every memory write from the transmitted stream: word i is bytes 4i..4i+3,
// little-endian, at BASE + 4i. Scenario tasks compare observed writes and
// status outputs against those predictions.

module tb_interpreter_receiver;

    localparam int          ADDR_W = 32;
    localparam logic [31:0] BASE   = 32'hFFFF_FFF8;

    logic        clk    = 1'b0;
    logic        reset  = 1'b0;
    logic        start  = 1'b0;
    logic        clk_in = 1'b0;
    logic [7:0]  DataIn = 8'h00;
    logic        MemWrite;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic        Busy;
    logic        Done;
    logic [31:0] WordCount;
    logic        ChkErr;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0]  payload[$];
    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];
    logic [31:0] obs_addr[$];
    logic [31:0] obs_data[$];
    logic        busy_after_start;
    logic        done_after_start;
    bit          done_ok;

    interpreter_receiver #(
        .ADDR_W   (ADDR_W),
        .BASE_ADDR(BASE)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .clk_in   (clk_in),
        .DataIn   (DataIn),
        .MemWrite (MemWrite),
        .Address  (Address),
        .WriteData(WriteData),
        .Busy     (Busy),
        .Done     (Done),
        .WordCount(WordCount),
        .ChkErr   (ChkErr)
    );

    always #5 clk = ~clk;

    // Record every write-enable cycle. A stuck write shows up as extra entries.
    always @(negedge clk) begin
        if (MemWrite === 1'b1) begin
            obs_addr.push_back(Address);
            obs_data.push_back(WriteData);
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation still running, required finish");
        $fatal(1, "[TB] watchdog");
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        DataIn = b;
        repeat (2) @(negedge clk);
        clk_in = 1'b1;
        repeat (5) @(negedge clk);
        clk_in = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        busy_after_start = Busy;
        done_after_start = Done;
    endtask

    task automatic fill_payload(input int n);
        payload.delete();
        for (int i = 0; i < 4 * n; i++) payload.push_back(8'($urandom));
    endtask

    // Reference: words assembled from the payload, addresses wrap mod 2^32.
    task automatic build_model(input int n);
        exp_addr.delete();
        exp_data.delete();
        for (int i = 0; i < n; i++) begin
            exp_addr.push_back(BASE + 32'(4 * i));
            exp_data.push_back({payload[4*i+3], payload[4*i+2],
                                payload[4*i+1], payload[4*i]});
        end
    endtask

    function automatic logic [7:0] payload_xor();
        logic [7:0] x = 8'h00;
        foreach (payload[i]) x ^= payload[i];
        return x;
    endfunction

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 80; i++) begin
            if (Done === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    // Full transfer of n words taken from payload. With the checksum build a
    // trailing checksum byte is sent, corrupted when bad_chk is set.
    task automatic run_transfer(input int n, input bit bad_chk);
        logic [15:0] len;
        len = 16'(n);
        obs_addr.delete();
        obs_data.delete();
        build_model(n);
        pulse_start();
        send_byte(len[15:8]);
        send_byte(len[7:0]);
        foreach (payload[i]) send_byte(payload[i]);
`ifdef RX_CHECKSUM_EN
        send_byte(payload_xor() ^ (bad_chk ? 8'h01 : 8'h00));
`else
        if (bad_chk) payload_xor();
`endif
        wait_done(done_ok);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({MemWrite, Address, WriteData, Busy, Done, WordCount, ChkErr} !==
            {1'b0, BASE, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0}) begin
            n_err++;
            $display("[TB] FAIL reset_values: got mw=%b a=%h wd=%h b=%b d=%b wc=%0d ce=%b, required 0 %h 0 0 0 0 0",
                     MemWrite, Address, WriteData, Busy, Done, WordCount, ChkErr, BASE);
        end
        reset = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_zero_length();
        payload.delete();
        run_transfer(0, 1'b0);
        n_cmp++;
        if (busy_after_start !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL zero_busy_after_start: got %b required 1", busy_after_start);
        end
        n_cmp++;
        if (!done_ok) begin
            n_err++;
            $display("[TB] FAIL zero_done: timeout, required Done=1");
        end
        n_cmp++;
        if ({Busy, WordCount, ChkErr} !== {1'b0, 32'h0, 1'b0}) begin
            n_err++;
            $display("[TB] FAIL zero_status: got busy=%b wc=%0d ce=%b required 0 0 0", Busy, WordCount, ChkErr);
        end
        n_cmp++;
        if (obs_addr.size() != 0) begin
            n_err++;
            $display("[TB] FAIL zero_writes: got %0d writes required 0", obs_addr.size());
        end
    endtask

    task automatic test_two_words();
        payload = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        run_transfer(2, 1'b0);
        n_cmp++;
        if ({busy_after_start, done_after_start} !== 2'b10) begin
            n_err++;
            $display("[TB] FAIL rearm_from_done: got busy=%b done=%b required 1 0", busy_after_start, done_after_start);
        end
        n_cmp++;
        if (obs_addr.size() != 2) begin
            n_err++;
            $display("[TB] FAIL two_count: got %0d writes required 2", obs_addr.size());
        end
        for (int i = 0; i < 2 && i < obs_addr.size(); i++) begin
            n_cmp++;
            if ({obs_addr[i], obs_data[i]} !== {BASE + 32'(4 * i), (i == 0) ? 32'h4433_2211 : 32'hDDCC_BBAA}) begin
                n_err++;
                $display("[TB] FAIL two_word%0d: got %h/%h required %h/%h", i, obs_addr[i], obs_data[i],
                         BASE + 32'(4 * i), (i == 0) ? 32'h4433_2211 : 32'hDDCC_BBAA);
            end
        end
        n_cmp++;
        if ({done_ok, Done, Busy, WordCount} !== {1'b1, 1'b1, 1'b0, 32'd2}) begin
            n_err++;
            $display("[TB] FAIL two_status: got done=%b busy=%b wc=%0d required 1 0 2", Done, Busy, WordCount);
        end
    endtask

    task automatic test_idle_strobes();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        send_byte(8'h00);
        send_byte(8'h07);
        send_byte(8'h5A);
        payload = '{8'h01, 8'h02, 8'h03, 8'h04};
        run_transfer(1, 1'b0);
        n_cmp++;
        if (obs_addr.size() != 1) begin
            n_err++;
            $display("[TB] FAIL idle_count: got %0d writes required 1", obs_addr.size());
        end else begin
            n_cmp++;
            if ({obs_addr[0], obs_data[0]} !== {BASE, 32'h0403_0201}) begin
                n_err++;
                $display("[TB] FAIL idle_word: got %h/%h required %h/04030201", obs_addr[0], obs_data[0], BASE);
            end
        end
    endtask

    task automatic test_reset_mid();
        obs_addr.delete();
        obs_data.delete();
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'hE1);
        send_byte(8'hE2);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({MemWrite, Address, WriteData, Busy, Done, WordCount, ChkErr} !==
            {1'b0, BASE, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0}) begin
            n_err++;
            $display("[TB] FAIL midreset_values: got mw=%b a=%h wd=%h b=%b d=%b wc=%0d ce=%b",
                     MemWrite, Address, WriteData, Busy, Done, WordCount, ChkErr);
        end
        reset = 1'b1;
        send_byte(8'hE3);
        send_byte(8'hE4);
        n_cmp++;
        if (obs_addr.size() != 0 || Busy !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL midreset_nowrite: got %0d writes busy=%b required 0 0", obs_addr.size(), Busy);
        end
        payload = '{8'h9A, 8'hBC, 8'hDE, 8'hF0};
        run_transfer(1, 1'b0);
        n_cmp++;
        if (obs_addr.size() != 1 || obs_data[0] !== 32'hF0DE_BC9A || WordCount !== 32'd1) begin
            n_err++;
            $display("[TB] FAIL midreset_fresh: got %0d writes wc=%0d required 1 write F0DEBC9A wc=1",
                     obs_addr.size(), WordCount);
        end
    endtask

    task automatic test_restart_ignored();
        fill_payload(2);
        build_model(2);
        obs_addr.delete();
        obs_data.delete();
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h02);
        for (int i = 0; i < 6; i++) send_byte(payload[i]);
        pulse_start();
        for (int i = 6; i < 8; i++) send_byte(payload[i]);
`ifdef RX_CHECKSUM_EN
        send_byte(payload_xor());
`endif
        wait_done(done_ok);
        n_cmp++;
        if (!done_ok || WordCount !== 32'd2 || obs_addr.size() != 2) begin
            n_err++;
            $display("[TB] FAIL restart_ignored: got done=%b wc=%0d writes=%0d required 1 2 2",
                     Done, WordCount, obs_addr.size());
        end else begin
            n_cmp++;
            if (obs_data[1] !== exp_data[1] || obs_addr[1] !== exp_addr[1]) begin
                n_err++;
                $display("[TB] FAIL restart_word1: got %h/%h required %h/%h",
                         obs_addr[1], obs_data[1], exp_addr[1], exp_data[1]);
            end
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 5; t++) begin
            int n;
            n = int'($urandom_range(0, 5));
            fill_payload(n);
            run_transfer(n, 1'b0);
            n_cmp++;
            if (!done_ok || WordCount !== 32'(n) || Busy !== 1'b0 || ChkErr !== 1'b0) begin
                n_err++;
                $display("[TB] FAIL rand%0d_status: got done=%b wc=%0d busy=%b ce=%b required 1 %0d 0 0",
                         t, Done, WordCount, Busy, ChkErr, n);
            end
            n_cmp++;
            if (obs_addr.size() != exp_addr.size()) begin
                n_err++;
                $display("[TB] FAIL rand%0d_count: got %0d writes required %0d", t, obs_addr.size(), exp_addr.size());
            end else begin
                for (int i = 0; i < exp_addr.size(); i++) begin
                    n_cmp++;
                    if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i]) begin
                        n_err++;
                        $display("[TB] FAIL rand%0d_word%0d: got %h/%h required %h/%h",
                                 t, i, obs_addr[i], obs_data[i], exp_addr[i], exp_data[i]);
                    end
                end
            end
        end
    endtask

`ifdef RX_CHECKSUM_EN
    task automatic test_checksum();
        payload = '{8'h01, 8'h02, 8'h03, 8'h04};
        run_transfer(1, 1'b0);
        n_cmp++;
        if (!done_ok || ChkErr !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL chk_good: got done=%b ce=%b required 1 0", Done, ChkErr);
        end
        run_transfer(1, 1'b1);
        n_cmp++;
        if (!done_ok || ChkErr !== 1'b1 || obs_addr.size() != 1 || obs_data[0] !== 32'h0403_0201) begin
            n_err++;
            $display("[TB] FAIL chk_bad: got done=%b ce=%b writes=%0d required 1 1 1", Done, ChkErr, obs_addr.size());
        end
    endtask
`endif

    initial begin
        test_reset();
        test_zero_length();
        test_two_words();
        test_idle_strobes();
        test_reset_mid();
        test_restart_ignored();
        test_random();
`ifdef RX_CHECKSUM_EN
        test_checksum();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
